rv32i_memory_responder: RTL and testbench

Memory/peripheral responder on the far end of the multicycle RV32I core's single-port memory bus (mem_addr, mem_wr_data, mem_wr_ena in; mem_rd_data out). It decodes each access to a word RAM or a small MMIO bank. The MMIO bank holds an LED register, a free-running cycle timer, and a byte FIFO that drains to a UART-style valid/ready transmit interface. Reads are registered with one cycle of latency, which the core's wait states absorb.

---
 rtl/rv32i_memory_responder.sv | 165 ++++++++++++++++
 tb/tb_rv32i_memory_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_memory_responder.sv
// rv32i_memory_responder: far end of the multicycle RV32I core's memory bus.
// Decodes each access to a word RAM (region 0x0) or a small MMIO bank
// (region 0xF: LED, TX FIFO, cycle timer, status). Reads are registered with
// one cycle of latency and return the pre-write value on a same-cycle write.
// Build option: define MMIO_TIMER_EN to implement the cycle timer; without it
// TIMER reads return 0 and TIMER writes are ignored.
module rv32i_memory_responder #(
  parameter int    RAM_WORDS = 512,
  parameter string INIT_FILE = "",
  parameter int    TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_TX     = 2'd1;
  localparam logic [1:0] OFF_TIMER  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   timer;
  logic [31:0]   rd_next;

  logic          sel_ram;
  logic          sel_mmio;
  logic [AW-1:0] word_idx;
  logic [1:0]    mmio_off;
  logic          bus_wr;
  logic          ram_wr;
  logic          led_wr;
  logic          push_req;
  logic          status_wr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          unused_addr_bits;

  assign sel_ram   = (mem_addr[31:28] == 4'h0);
  assign sel_mmio  = (mem_addr[31:28] == 4'hF);
  assign word_idx  = mem_addr[AW+1:2];
  assign mmio_off  = mem_addr[3:2];
  assign bus_wr    = ena & mem_wr_ena;
  assign ram_wr    = bus_wr & sel_ram;
  assign led_wr    = bus_wr & sel_mmio & (mmio_off == OFF_LED);
  assign push_req  = bus_wr & sel_mmio & (mmio_off == OFF_TX);
  assign status_wr = bus_wr & sel_mmio & (mmio_off == OFF_STATUS);

  // Upper RAM index bits alias and the low byte-offset bits are ignored.
  assign unused_addr_bits = ^{mem_addr[27:AW+2], mem_addr[1:0]};

  assign full     = (count == CW'(TX_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = ~empty;
  assign pop      = tx_valid & tx_ready;
  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign push     = push_req & (~full | pop);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // Select the word that the current address would read, before any write this cycle lands.
  always_comb begin
    rd_next = 32'h0;
    if (sel_ram) begin
      rd_next = ram[word_idx];
    end else if (sel_mmio) begin
      case (mmio_off)
        OFF_LED:    rd_next = {24'h0, leds};
        OFF_TX:     rd_next = 32'(count);
        OFF_TIMER:  rd_next = timer;
        OFF_STATUS: rd_next = {29'h0, overflow, empty, full};
        default:    rd_next = 32'h0;
      endcase
    end
  end

  // RAM array: no reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram[word_idx] <= mem_wr_data;
    end
  end

  // Registered read data and LED register; read data holds while the bus is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_data <= 32'h0;
      leds        <= 8'h0;
    end else begin
      if (ena) begin
        mem_rd_data <= rd_next;
      end
      if (led_wr) begin
        leds <= mem_wr_data[7:0];
      end
    end
  end

  // FIFO storage: contents are don't-care whenever count says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_wr_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (status_wr) begin
        overflow <= 1'b0;
      end else if (push_req & ~push) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MMIO_TIMER_EN
  logic timer_clr;
  assign timer_clr = bus_wr & sel_mmio & (mmio_off == OFF_TIMER);

  // Free-running cycle timer; a bus write clears it and takes priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 32'h0;
    end else if (timer_clr) begin
      timer <= 32'h0;
    end else if (ena) begin
      timer <= timer + 32'd1;
    end
  end
`else
  assign timer = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_memory_responder.sv
// tb_rv32i_memory_responder: directed scoreboard bench for rv32i_memory_responder.
// Expected read data and transmitted bytes are queued by the stimulus and
// consumed by independent monitors.
module tb_rv32i_memory_responder;

  localparam logic [31:0] A_LED    = 32'hF000_0000;
  localparam logic [31:0] A_TX     = 32'hF000_0004;
  localparam logic [31:0] A_TIMER  = 32'hF000_0008;
  localparam logic [31:0] A_STATUS = 32'hF000_000C;

`ifdef MMIO_TIMER_EN
  localparam logic [31:0] TIMER_EXP1 = 32'd10;
  localparam logic [31:0] TIMER_EXP2 = 32'd11;
`else
  localparam logic [31:0] TIMER_EXP1 = 32'd0;
  localparam logic [31:0] TIMER_EXP2 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wr_data = 32'h0;
  logic        mem_wr_ena = 1'b0;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  logic        rd_issue = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];

  int checks = 0;
  int errors = 0;

  rv32i_memory_responder dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .leds        (leds),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle, driven on the falling edge; optionally queues the expected read data.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic en, input logic rdy,
                               input logic chk, input logic [31:0] exp, input string name);
    @(negedge clk);
    mem_addr    = addr;
    mem_wr_data = wdata;
    mem_wr_ena  = we;
    ena         = en;
    tx_ready    = rdy;
    rd_issue    = chk;
    if (chk) begin
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
    end
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic rdy);
    applyStimulus(addr, wdata, 1'b1, 1'b1, rdy, 1'b0, 32'h0, "");
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [31:0] exp, input string name,
                        input logic rdy);
    applyStimulus(addr, 32'h0, 1'b0, 1'b1, rdy, 1'b1, exp, name);
  endtask

  task automatic doIdle(input logic en, input logic rdy);
    applyStimulus(32'h0, 32'h0, 1'b0, en, rdy, 1'b0, 32'h0, "");
  endtask

  // Read monitor: one cycle after a checked read is sampled, compare against the queue head.
  initial begin
    logic issued;
    forever begin
      @(posedge clk);
      issued = rd_issue;
      #1;
      if (issued) begin
        if (rd_exp_q.size() == 0) begin
          checkOutput("rd_queue_underflow", 32'h1, 32'h0);
        end else begin
          checkOutput(rd_name_q.pop_front(), mem_rd_data, rd_exp_q.pop_front());
        end
      end
    end
  end

  // Transmit monitor: every accepted handshake must carry the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && tx_valid && tx_ready) begin
        if (tx_exp_q.size() == 0) begin
          checkOutput("tx_unexpected_pop", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_rd_data", mem_rd_data, 32'h0);
    checkOutput("reset_leds", {24'h0, leds}, 32'h0);
    checkOutput("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("reset_tx_data", {24'h0, tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // RAM write, read back, alias, unmapped region.
    doWrite(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    doRead(32'h0000_0010, 32'hDEAD_BEEF, "ram_read", 1'b0);
    doRead(32'h0000_0810, 32'hDEAD_BEEF, "ram_alias", 1'b0);
    doWrite(32'h2000_0010, 32'h1111_2222, 1'b0);
    doRead(32'h2000_0010, 32'h0, "unmapped_read", 1'b0);
    doRead(32'h0000_0010, 32'hDEAD_BEEF, "ram_after_unmapped_wr", 1'b0);
    doWrite(32'h0000_0014, 32'h0BAD_F00D, 1'b0);
    applyStimulus(32'h0000_0014, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, "ram_rbw_old");
    doRead(32'h0000_0014, 32'h1234_5678, "ram_rbw_new", 1'b0);

    // LED register with read-before-write and bank aliasing.
    doWrite(A_LED, 32'h0000_0012, 1'b0);
    applyStimulus(A_LED, 32'h0000_0034, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12, "led_rbw_old");
    doRead(A_LED, 32'h34, "led_rbw_new", 1'b0);
    doRead(32'hF000_0010, 32'h34, "led_alias", 1'b0);
    checkOutput("leds_port", {24'h0, leds}, 32'h34);

    // Fill FIFO past capacity with the sink stalled.
    for (int i = 0; i < 5; i++) begin
      doWrite(A_TX, 32'h41 + i, 1'b0);
      if (i < 4) tx_exp_q.push_back(8'(8'h41 + i));
    end
    doRead(A_TX, 32'd4, "fifo_count_full", 1'b0);
    doRead(A_STATUS, 32'b101, "status_full_ovf", 1'b0);
    checkOutput("tx_head", {24'h0, tx_data}, 32'h41);
    checkOutput("tx_valid_full", {31'h0, tx_valid}, 32'h1);

    // Drain with the sink ready; the monitor checks order.
    repeat (4) doIdle(1'b1, 1'b1);
    doIdle(1'b1, 1'b0);
    doRead(A_STATUS, 32'b110, "status_empty_ovf", 1'b0);
    doWrite(A_STATUS, 32'h0, 1'b0);
    doRead(A_STATUS, 32'b010, "status_ovf_cleared", 1'b0);

    // Full FIFO: push and pop in the same cycle keeps count and no overflow.
    for (int i = 0; i < 4; i++) begin
      doWrite(A_TX, 32'h51 + i, 1'b0);
      tx_exp_q.push_back(8'(8'h51 + i));
    end
    doRead(A_TX, 32'd4, "fifo_count_refill", 1'b0);
    doWrite(A_TX, 32'h55, 1'b1);
    tx_exp_q.push_back(8'h55);
    doRead(A_TX, 32'd4, "fifo_count_pushpop", 1'b0);
    doRead(A_STATUS, 32'b001, "status_pushpop_no_ovf", 1'b0);
    repeat (4) doIdle(1'b1, 1'b1);
    doIdle(1'b1, 1'b0);
    doRead(A_STATUS, 32'b010, "status_drained", 1'b0);

    // Timer: clear, count 10 cycles, then hold while the bus is disabled.
    doWrite(A_TIMER, 32'h0000_FFFF, 1'b0);
    repeat (10) doIdle(1'b1, 1'b0);
    doRead(A_TIMER, TIMER_EXP1, "timer_10_cycles", 1'b0);
    applyStimulus(A_LED, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, TIMER_EXP1, "rd_hold_ena0");
    applyStimulus(A_LED, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "");
    repeat (3) doIdle(1'b0, 1'b0);
    doRead(A_TIMER, TIMER_EXP2, "timer_hold_ena0", 1'b0);
    doRead(A_LED, 32'h34, "led_write_ignored_ena0", 1'b0);

    // Async reset in the middle of activity.
    for (int i = 0; i < 3; i++) doWrite(A_TX, 32'h61 + i, 1'b0);
    doWrite(A_LED, 32'hFF, 1'b0);
    doRead(A_LED, 32'hFF, "led_ff", 1'b0);
    @(posedge clk);
    #2 rd_issue = 1'b0;
    #1;
    checkOutput("pre_reset_tx_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("pre_reset_leds", {24'h0, leds}, 32'hFF);
    rst = 1'b1;
    #1;
    checkOutput("async_rd_data", mem_rd_data, 32'h0);
    checkOutput("async_leds", {24'h0, leds}, 32'h0);
    checkOutput("async_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("async_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    doRead(A_TX, 32'd0, "fifo_count_after_reset", 1'b0);
    doRead(A_STATUS, 32'b010, "status_after_reset", 1'b0);
    doRead(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept_over_reset", 1'b0);
    doIdle(1'b1, 1'b0);
    checkOutput("tx_valid_after_reset", {31'h0, tx_valid}, 32'h0);

    // Let the monitors consume everything that was queued.
    for (int i = 0; i < 20 && (rd_exp_q.size() != 0 || tx_exp_q.size() != 0); i++) begin
      @(negedge clk);
    end
    checkOutput("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);
    checkOutput("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
